mux2_stream_arb: RTL and testbench
==================================

# mux2_stream_arb

Two-input valid/ready stream arbiter that drives the select of the team's `mux2to1` data cell and registers the winning beat into a single output stage. It sits directly upstream of the 2:1 mux: it decides `sel` each cycle and consumes the mux output into a registered, back-pressurable stream. Round-robin fairness applies when both sources are valid. Per-source accepted-beat counters are provided for debug and coverage.

## Interface
- `WIDTH`, 8: data width of each channel.
- `CNT_W`, 8: width of the per-source beat counters.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a_valid` input 1: source A has a beat.
- `a_data` input WIDTH: source A payload.
- `a_ready` output 1: source A beat accepted this cycle.
- `b_valid` input 1: source B has a beat.
- `b_data` input WIDTH: source B payload.
- `b_ready` output 1: source B beat accepted this cycle.
- `sel` output 1: mux select, 0 = A, 1 = B; combinational.
- `out_valid` output 1: output register holds a beat.
- `out_data` output WIDTH: registered payload.
- `out_src` output 1: source of the registered beat, 0 = A, 1 = B.
- `out_ready` input 1: downstream accepts the beat.
- `cnt_a` output CNT_W: beats accepted from A; wraps modulo 2^CNT_W.
- `cnt_b` output CNT_W: beats accepted from B; wraps modulo 2^CNT_W.

## Operation
- Output stage state: EMPTY (`out_valid`=0) or FULL (`out_valid`=1).
- `load = !out_valid || out_ready`. This permits a full-throughput drain-and-refill in the same cycle.
- Grant selection (combinational):
  - only A valid -> A;
  - only B valid -> B;
  - both valid -> the source indicated by the `prio` register;
  - neither valid -> `sel` = `prio`, no grant.
- `sel` = 1 when B is granted, else as defined above. `sel` drives the `mux2to1` bank.
- `a_ready = load && grant_a`; `b_ready = load && grant_b`. At most one ready is high per cycle.
- On an accepted beat (`load` && a grant):
  - `out_data` <= mux output;
  - `out_src` <= `sel`;
  - `out_valid` <= 1;
  - the matching counter increments.
- On `out_ready` with no accepted beat, `out_valid` <= 0. `out_data` and `out_src` hold their values.
- `prio` update:
  - flips to the non-granted source only when both were valid and a beat was accepted;
  - a single-source grant sets `prio` to the other source;
  - otherwise `prio` holds.
- Valid is never dependent on ready. Ready may depend on valid, `prio`, and `out_ready`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `prio`=0 (A first), `cnt_a`=0, `cnt_b`=0.
- During reset, `a_ready`/`b_ready` are 0, because `load` is forced 0 while `rst_n` is low.
- Latency: a beat accepted in cycle N appears on `out_*` in cycle N+1.
- Throughput: 1 beat/cycle while `out_ready`=1. Alternates A,B,A,B when both sources are continuously valid.
- FULL with `out_ready`=0 and both sources valid: no ready is asserted, and `prio`, the counters and `out_*` all hold.
- Counter wrap: the value 2^CNT_W-1 followed by one more accepted beat becomes 0, with no flag.
- Reset asserted mid-transfer: all state clears immediately. Any beat in the output register is dropped. After release, the first grant uses `prio`=0.

## Structure
- Package `mux2_arb_pkg`:
  - `typedef enum logic {SRC_A=1'b0, SRC_B=1'b1} src_e`, used for `prio`, `sel` and `out_src`;
  - default-width localparams.
- Sub-module: WIDTH instances of the existing `mux2to1` in a generate loop. Each instance takes `a_data[i]`, `b_data[i]` and `sel`. The arbiter logic and output register live in the top module.

## Test plan
- Reset release, only A valid with `a_data`=0x11, `out_ready`=1:
  - `a_ready`=1 in cycle 0;
  - `out_data`=0x11, `out_src`=0 in cycle 1;
  - `cnt_a`=1.
- Both valid (A=0x0A, B=0x0B) for 4 cycles, `out_ready`=1: `out_src` sequence 0,1,0,1 and `cnt_a`=`cnt_b`=2.
- Both valid, `out_ready`=0 after the first beat:
  - `out_valid` stays 1 and `out_data` is held;
  - `a_ready`=`b_ready`=0;
  - `prio` is unchanged until `out_ready` rises, then B is served.
- Only B valid for 3 beats, then both valid: the first both-valid grant goes to A.
- CNT_W=2, 5 A beats: `cnt_a` sequence 1,2,3,0,1.
- `rst_n` pulled low while `out_valid`=1: `out_valid`=0, counters are 0 and `sel`=0 immediately (asynchronously). After release, the first grant with both valid goes to A.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// Shared types and default widths for the two-input stream arbiter.
package mux2_arb_pkg;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} stage_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/mux2to1.sv
// Single-bit 2:1 data cell; sel=0 passes a, sel=1 passes b.
module mux2to1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_stream_arb.sv
// Round-robin arbiter for two valid/ready sources feeding a mux2to1 bank,
// with a single registered output stage and per-source beat counters.
//
// state    | meaning
// ST_EMPTY | output register holds no beat (out_valid=0)
// ST_FULL  | output register holds a beat awaiting out_ready
module mux2_stream_arb
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  stage_e           state_q, state_d;
  src_e             prio_q, sel_s, out_src_q;
  logic             grant_a, grant_b, load, accept;
  logic [WIDTH-1:0] mux_y, out_data_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux2to1 u_mux (
      .a   (a_data[i]),
      .b   (b_data[i]),
      .sel (sel_s),
      .y   (mux_y[i])
    );
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    sel_s   = prio_q;
    if (a_valid && b_valid) begin
      grant_a = (prio_q == SRC_A);
      grant_b = (prio_q == SRC_B);
    end else if (a_valid) begin
      grant_a = 1'b1;
      sel_s   = SRC_A;
    end else if (b_valid) begin
      grant_b = 1'b1;
      sel_s   = SRC_B;
    end
  end

  // rst_n gates load so no source sees ready while the stage is held in reset
  assign load    = rst_n && ((state_q == ST_EMPTY) || out_ready);
  assign accept  = load && (grant_a || grant_b);
  assign a_ready = load && grant_a;
  assign b_ready = load && grant_b;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_FULL;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_src_q  <= SRC_A;
      prio_q     <= SRC_A;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
    end else if (accept) begin
      out_data_q <= mux_y;
      out_src_q  <= sel_s;
      // Next priority always goes to whichever source was not just served
      prio_q     <= (sel_s == SRC_A) ? SRC_B : SRC_A;
      if (grant_a) cnt_a_q <= cnt_a_q + 1'b1;
      if (grant_b) cnt_b_q <= cnt_b_q + 1'b1;
    end
  end

  assign sel       = sel_s;
  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_mux2_stream_arb.sv
// Directed bench for mux2_stream_arb; a second instance with 2-bit counters
// shares the stimulus to exercise counter wrap.
module tb_mux2_stream_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, out_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, sel, out_valid, out_src;
  logic [7:0] out_data, cnt_a, cnt_b;
  logic       a_ready2, b_ready2, sel2, out_valid2, out_src2;
  logic [7:0] out_data2;
  logic [1:0] cnt_a2, cnt_b2;

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mux2_stream_arb #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  mux2_stream_arb #(.WIDTH(8), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready2),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready2),
    .sel(sel2), .out_valid(out_valid2), .out_data(out_data2), .out_src(out_src2),
    .out_ready(out_ready), .cnt_a(cnt_a2), .cnt_b(cnt_b2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic exp_src [4];
    logic [1:0] exp_w2 [5];
    exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_w2  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset state, with both sources requesting
    rst_n = 1'b0; out_ready = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h0A; b_data = 8'h0B;
    step(); step();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_sel", sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);

    // Only A valid after release
    rst_n = 1'b1; b_valid = 1'b0; a_data = 8'h11;
    #1;
    chk("a_only_ready", a_ready, 1);
    step();
    chk("a_only_out_valid", out_valid, 1);
    chk("a_only_out_data", out_data, 8'h11);
    chk("a_only_out_src", out_src, 0);
    chk("a_only_cnt_a", cnt_a, 1);

    // Both valid, continuous drain: strict alternation
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h0A; b_data = 8'h0B;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_src%0d", i), out_src, exp_src[i]);
      chk($sformatf("rr_data%0d", i), out_data, exp_src[i] ? 8'h0B : 8'h0A);
    end
    chk("rr_cnt_a", cnt_a, 2);
    chk("rr_cnt_b", cnt_b, 2);

    // Back-pressure after the first beat
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    step();
    chk("bp_first_data", out_data, 8'h0A);
    out_ready = 1'b0;
    #1;
    chk("bp_a_ready", a_ready, 0);
    chk("bp_b_ready", b_ready, 0);
    chk("bp_sel_prio", sel, 1);
    step(); step();
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_data", out_data, 8'h0A);
    chk("bp_cnt_a", cnt_a, 1);
    chk("bp_cnt_b", cnt_b, 0);
    chk("bp_sel_hold", sel, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_rel_b_ready", b_ready, 1);
    chk("bp_rel_a_ready", a_ready, 0);
    step();
    chk("bp_rel_data", out_data, 8'h0B);
    chk("bp_rel_src", out_src, 1);

    // B alone for three beats, then both: A wins first
    do_reset();
    b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("b_only_cnt%0d", i), cnt_b, i + 1);
    end
    chk("b_only_src", out_src, 1);
    a_valid = 1'b1;
    #1;
    chk("b_then_both_sel", sel, 0);
    chk("b_then_both_a_ready", a_ready, 1);
    step();
    chk("b_then_both_src", out_src, 0);
    chk("b_then_both_data", out_data, 8'h0A);

    // Counter wrap on the 2-bit instance
    do_reset();
    a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("wrap_cnt%0d", i), cnt_a2, exp_w2[i]);
    end
    chk("wrap_wide_cnt", cnt_a, 5);

    // Asynchronous reset while a beat is held
    b_valid = 1'b1;
    out_ready = 1'b0;
    step();
    chk("ar_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_cnt_a", cnt_a, 0);
    chk("ar_cnt_b", cnt_b, 0);
    chk("ar_sel", sel, 0);
    chk("ar_a_ready", a_ready, 0);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("ar_post_a_ready", a_ready, 1);
    step();
    chk("ar_post_src", out_src, 0);
    chk("ar_post_cnt_a", cnt_a, 1);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
